btb_update_ctrl: RTL

//  Write-side controller for the 4-way, 8-set BTB datapath. Accepts resolved-branch

---
 rtl/btb_update_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: write-side controller for the 4-way, 8-set BTB.
// Buffers resolved taken-branch updates, borrows the BTB read port to probe the
// target set, chooses the hitting way or the pseudo-LRU victim, then issues a
// single-cycle way write together with an LRU array update.
module btb_update_ctrl #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [15:0]      upd_pc,
  input  logic [15:0]      upd_target,
  input  logic             upd_taken,
  output logic             probe_req,
  input  logic             probe_grant,
  output logic [15:0]      probe_pc,
  input  logic             wb_hit,
  input  logic [3:0]       wb_comp,
  input  logic [2:0]       lru_out,
  output logic [3:0]       way_write,
  output logic             lru_load,
  output logic [15:0]      old_pc_addr,
  output logic [15:0]      wb_addr,
  output logic             busy,
  output logic [CNT_W-1:0] alloc_cnt,
  output logic [CNT_W-1:0] upd_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               hit_q, hit_d;
  logic [3:0]         way_oh_q, way_oh_d;
  logic [CNT_W-1:0]   alloc_cnt_q, alloc_cnt_d;
  logic [CNT_W-1:0]   upd_cnt_q, upd_cnt_d;

  logic [15:0]        pc_mem_q  [FIFO_DEPTH];
  logic [15:0]        pc_mem_d  [FIFO_DEPTH];
  logic [15:0]        tgt_mem_q [FIFO_DEPTH];
  logic [15:0]        tgt_mem_d [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake / FIFO status
  // ---------------------------------------------------------------------------
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic [15:0] head_pc;
  logic [15:0] head_tgt;
  logic [3:0]  sel_way_oh;

  assign fifo_full  = (occ_q == FULL_OCC);
  assign fifo_empty = (occ_q == '0);
  // Ready depends only on registered occupancy, so a pop frees the slot one
  // cycle later rather than combinationally.
  assign upd_ready  = ~fifo_full;
  assign accept     = upd_valid & upd_ready;
  // Not-taken updates are consumed but never stored: there is no invalidate path.
  assign push       = accept & upd_taken;
  // The write (and the pop) happens only while fetch has handed us the read port,
  // because the LRU update depends on lru_out being indexed by the probe address.
  assign pop        = (state_q == S_WRITE) & probe_grant;

  assign head_pc    = pc_mem_q[rd_ptr_q];
  assign head_tgt   = tgt_mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // FIFO storage: one register slot per entry, written when the write pointer
  // selects it.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      // Capture the pushed pc/target into this slot when it is the write target.
      always_comb begin
        pc_mem_d[gi]  = pc_mem_q[gi];
        tgt_mem_d[gi] = tgt_mem_q[gi];
        if (push && (wr_ptr_q == PTR_W'(gi))) begin
          pc_mem_d[gi]  = upd_pc;
          tgt_mem_d[gi] = upd_target;
        end
      end

      // Slot registers; contents are discarded on reset.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pc_mem_q[gi]  <= '0;
          tgt_mem_q[gi] <= '0;
        end else begin
          pc_mem_q[gi]  <= pc_mem_d[gi];
          tgt_mem_q[gi] <= tgt_mem_d[gi];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Way selection from the probe response: lowest hitting way on a hit,
  // otherwise the tree pseudo-LRU victim (lru_out[2] picks the half, then
  // lru_out[1] or lru_out[0] picks the way inside that half).
  // ---------------------------------------------------------------------------
  // Decode probe response into a one-hot way.
  always_comb begin
    sel_way_oh = 4'b0000;
    if (wb_hit) begin
      for (int i = 3; i >= 0; i--) begin
        if (wb_comp[i]) begin
          sel_way_oh = 4'b0001 << i;
        end
      end
    end else if (!lru_out[2]) begin
      sel_way_oh = lru_out[1] ? 4'b0010 : 4'b0001;
    end else begin
      sel_way_oh = lru_out[0] ? 4'b1000 : 4'b0100;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy, FSM, probe capture and counters.
  // ---------------------------------------------------------------------------
  // Next-state logic for the controller.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    state_d     = state_q;
    hit_d       = hit_q;
    way_oh_d    = way_oh_q;
    alloc_cnt_d = alloc_cnt_q;
    upd_cnt_d   = upd_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        // Probe response is only meaningful in a granted cycle; latch it then.
        if (probe_grant) begin
          hit_d    = wb_hit;
          way_oh_d = sel_way_oh;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (probe_grant) begin
          if (hit_q) begin
            upd_cnt_d = (upd_cnt_q != CNT_MAX) ? upd_cnt_q + 1'b1 : upd_cnt_q;
          end else begin
            alloc_cnt_d = (alloc_cnt_q != CNT_MAX) ? alloc_cnt_q + 1'b1 : alloc_cnt_q;
          end
          // A same-cycle push also counts as "another entry pending".
          state_d = (occ_d != '0) ? S_PROBE : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      hit_q       <= 1'b0;
      way_oh_q    <= 4'b0000;
      alloc_cnt_q <= '0;
      upd_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      hit_q       <= hit_d;
      way_oh_q    <= way_oh_d;
      alloc_cnt_q <= alloc_cnt_d;
      upd_cnt_q   <= upd_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decodes of registered state; the write strobes are additionally
  // qualified by the grant so nothing is written without the probe index.
  // ---------------------------------------------------------------------------
  assign probe_req   = (state_q != S_IDLE);
  assign probe_pc    = probe_req ? head_pc : 16'h0000;
  assign old_pc_addr = (state_q == S_WRITE) ? head_pc  : 16'h0000;
  assign wb_addr     = (state_q == S_WRITE) ? head_tgt : 16'h0000;
  assign way_write   = pop ? way_oh_q : 4'b0000;
  assign lru_load    = pop;
  assign busy        = ~fifo_empty | (state_q != S_IDLE);
  assign alloc_cnt   = alloc_cnt_q;
  assign upd_cnt     = upd_cnt_q;

endmodule
